// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Conditions raw plant signals into the sensor-side inputs of manufacturing_fsm.
//   - metal, e-stop and reset-button contacts: 2-flop synchroniser, then a
//     debouncer that accepts a level after DEBOUNCE_CYCLES consecutive samples.
//   - temperature: hysteresis flag, hot at >= TEMP_HIGH, normal at <= TEMP_LOW.
//   - current: sticky overcurrent after OC_CYCLES consecutive samples > CUR_LIMIT.
//   - optional temperature-feed watchdog, built only when SENSOR_WDOG_EN is
//     defined; otherwise error is tied low.
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   metal_raw      raw metal sensor contact (async)
//   estop_raw      raw emergency-stop contact (async)
//   reset_btn_raw  raw operator reset button (async)
//   temp_code      temperature sample, qualified by temp_valid
//   temp_valid     one-cycle sample strobe
//   current_code   current sample, every cycle
//   metal_detected one-cycle pulse per accepted metal rising edge
//   high_temp      hysteresis hot flag
//   temp_normal    complement of high_temp
//   overcurrent    sticky overcurrent trip, cleared by a reset_btn pulse
//   error          sticky temperature-feed fault, cleared by a reset_btn pulse
//   emergency      debounced e-stop level
//   reset_btn      one-cycle pulse per accepted button press
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TEMP_W          = 8,
  parameter int unsigned TEMP_HIGH       = 80,
  parameter int unsigned TEMP_LOW        = 70,
  parameter int unsigned CUR_W           = 8,
  parameter int unsigned CUR_LIMIT       = 200,
  parameter int unsigned OC_CYCLES       = 3,
  parameter int unsigned WDOG_CYCLES     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              metal_raw,
  input  logic              estop_raw,
  input  logic              reset_btn_raw,
  input  logic [TEMP_W-1:0] temp_code,
  input  logic              temp_valid,
  input  logic [CUR_W-1:0]  current_code,
  output logic              metal_detected,
  output logic              high_temp,
  output logic              temp_normal,
  output logic              overcurrent,
  output logic              error,
  output logic              emergency,
  output logic              reset_btn
);

  localparam int unsigned NCH      = 3;
  localparam int unsigned CH_METAL = 0;
  localparam int unsigned CH_ESTOP = 1;
  localparam int unsigned CH_BTN   = 2;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [TEMP_W-1:0] T_HI = TEMP_W'(TEMP_HIGH);
  localparam logic [TEMP_W-1:0] T_LO = TEMP_W'(TEMP_LOW);
  localparam logic [CUR_W-1:0]  C_LIM = CUR_W'(CUR_LIMIT);

  localparam int unsigned OC_W = $clog2(OC_CYCLES + 1);
  localparam logic [OC_W-1:0] OC_TRIP = OC_W'(OC_CYCLES);

  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } db_state_e;

  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] db_level;

  assign raw_in = {reset_btn_raw, estop_raw, metal_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_db
    db_state_e       state;
    logic [DB_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= STABLE_LO;
        count <= '0;
      end else if (sync2[ch] == (state == STABLE_HI)) begin
        count <= '0;
      end else if (count == DB_LAST) begin
        state <= (state == STABLE_HI) ? STABLE_LO : STABLE_HI;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end

    assign db_level[ch] = (state == STABLE_HI);
  end

  assign emergency = db_level[CH_ESTOP];

  // Rising-edge pulses are registered, so they trail the level change by a cycle.
  logic metal_lvl_q;
  logic btn_lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      metal_lvl_q    <= 1'b0;
      btn_lvl_q      <= 1'b0;
      metal_detected <= 1'b0;
      reset_btn      <= 1'b0;
    end else begin
      metal_lvl_q    <= db_level[CH_METAL];
      btn_lvl_q      <= db_level[CH_BTN];
      metal_detected <= db_level[CH_METAL] & ~metal_lvl_q;
      reset_btn      <= db_level[CH_BTN] & ~btn_lvl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_temp   <= 1'b0;
      temp_normal <= 1'b1;
    end else if (temp_valid) begin
      if (temp_code >= T_HI) begin
        high_temp   <= 1'b1;
        temp_normal <= 1'b0;
      end else if (temp_code <= T_LO) begin
        high_temp   <= 1'b0;
        temp_normal <= 1'b1;
      end
    end
  end

  logic            over_limit;
  logic [OC_W-1:0] oc_cnt;
  logic [OC_W-1:0] oc_cnt_next;

  always_comb begin
    over_limit  = (current_code > C_LIM);
    oc_cnt_next = '0;
    if (over_limit) begin
      oc_cnt_next = (oc_cnt == OC_TRIP) ? oc_cnt : oc_cnt + 1'b1;
    end
  end

  // A button press wins over a trip on the same cycle; a concurrent
  // over-limit sample still counts as the first of a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_cnt      <= '0;
      overcurrent <= 1'b0;
    end else if (reset_btn) begin
      oc_cnt      <= over_limit ? OC_W'(1) : '0;
      overcurrent <= 1'b0;
    end else begin
      oc_cnt <= oc_cnt_next;
      if (oc_cnt_next == OC_TRIP) begin
        overcurrent <= 1'b1;
      end
    end
  end

`ifdef SENSOR_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_cnt_next;

  always_comb begin
    wd_cnt_next = wd_cnt;
    if (temp_valid) begin
      wd_cnt_next = '0;
    end else if (wd_cnt != WD_TRIP) begin
      wd_cnt_next = wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      error  <= 1'b0;
    end else if (reset_btn) begin
      wd_cnt <= '0;
      error  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_next;
      if (wd_cnt_next == WD_TRIP) begin
        error <= 1'b1;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: a window/run-length model of the
// conditioning rules is compared against every output on each falling edge,
// and directed scenarios pin event timing with hand-derived constants.
module tb_sensor_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TW   = 8;
  localparam int unsigned THI  = 80;
  localparam int unsigned TLO  = 70;
  localparam int unsigned CW   = 8;
  localparam int unsigned CLIM = 200;
  localparam int unsigned OCN  = 3;
  localparam int unsigned WDN  = 16;

  logic          clk           = 1'b0;
  logic          rst           = 1'b0;
  logic          metal_raw     = 1'b0;
  logic          estop_raw     = 1'b0;
  logic          reset_btn_raw = 1'b0;
  logic [TW-1:0] temp_code     = '0;
  logic          temp_valid    = 1'b0;
  logic [CW-1:0] current_code  = '0;
  logic          metal_detected;
  logic          high_temp;
  logic          temp_normal;
  logic          overcurrent;
  logic          error;
  logic          emergency;
  logic          reset_btn;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          chk_en = 1'b0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .TEMP_W         (TW),
    .TEMP_HIGH      (THI),
    .TEMP_LOW       (TLO),
    .CUR_W          (CW),
    .CUR_LIMIT      (CLIM),
    .OC_CYCLES      (OCN),
    .WDOG_CYCLES    (WDN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .metal_raw     (metal_raw),
    .estop_raw     (estop_raw),
    .reset_btn_raw (reset_btn_raw),
    .temp_code     (temp_code),
    .temp_valid    (temp_valid),
    .current_code  (current_code),
    .metal_detected(metal_detected),
    .high_temp     (high_temp),
    .temp_normal   (temp_normal),
    .overcurrent   (overcurrent),
    .error         (error),
    .emergency     (emergency),
    .reset_btn     (reset_btn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Contacts: raw value reaches the debouncer two edges late; the accepted
  // level flips when the last DEB samples all disagree with it.
  bit [2:0]     m_d1, m_d2, m_lvl, m_rise;
  bit [DEB-1:0] m_win [3];
  bit           m_md, m_rb, m_hi, m_oc, m_err;
  int unsigned  m_run;
`ifdef SENSOR_WDOG_EN
  int unsigned  m_gap;
`endif

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0;
    for (int unsigned ch = 0; ch < 3; ch++) m_win[ch] = '0;
    m_md = 0; m_rb = 0; m_hi = 0; m_oc = 0; m_err = 0; m_run = 0;
`ifdef SENSOR_WDOG_EN
    m_gap = 0;
`endif
  endtask

  task automatic model_step();
    bit [2:0] smp;
    bit       press;
    bit       over;
    smp   = m_d2;
    m_d2  = m_d1;
    m_d1  = {reset_btn_raw, estop_raw, metal_raw};
    press = m_rb;
    m_md  = m_rise[0];
    m_rb  = m_rise[2];
    for (int unsigned ch = 0; ch < 3; ch++) begin
      m_win[ch]  = {m_win[ch][DEB-2:0], smp[ch]};
      m_rise[ch] = 1'b0;
      if (m_win[ch] == {DEB{~m_lvl[ch]}}) begin
        m_lvl[ch]  = ~m_lvl[ch];
        m_rise[ch] = m_lvl[ch];
      end
    end
    if (temp_valid) begin
      if (int'(temp_code) >= THI) m_hi = 1;
      else if (int'(temp_code) <= TLO) m_hi = 0;
    end
    over = (int'(current_code) > CLIM);
    if (press) begin
      m_run = over ? 1 : 0;
      m_oc  = 0;
    end else begin
      m_run = over ? m_run + 1 : 0;
      if (m_run >= OCN) m_oc = 1;
    end
`ifdef SENSOR_WDOG_EN
    if (press) begin
      m_gap = 0;
      m_err = 0;
    end else begin
      m_gap = temp_valid ? 0 : m_gap + 1;
      if (m_gap >= WDN) m_err = 1;
    end
`endif
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("metal_detected", metal_detected, m_md);
      check("reset_btn",      reset_btn,      m_rb);
      check("emergency",      emergency,      m_lvl[1]);
      check("high_temp",      high_temp,      m_hi);
      check("temp_normal",    temp_normal,    !m_hi);
      check("overcurrent",    overcurrent,    m_oc);
      check("error",          error,          m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  // Holds the button until its pulse is visible; returns on that falling edge.
  task automatic press_button();
    bit seen;
    seen = 0;
    reset_btn_raw = 1'b1;
    for (int unsigned i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (reset_btn) seen = 1;
    end
    check("rb_pulse_seen", seen, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_metal"},  metal_detected, 0);
    check({tag, "_hot"},    high_temp,      0);
    check({tag, "_normal"}, temp_normal,    1);
    check({tag, "_oc"},     overcurrent,    0);
    check({tag, "_err"},    error,          0);
    check({tag, "_estop"},  emergency,      0);
    check({tag, "_rbtn"},   reset_btn,      0);
  endtask

  int unsigned temps  [5] = '{60, 85, 75, 71, 70};
  bit          hot_exp[5] = '{0, 1, 1, 1, 0};
  int unsigned curs   [6] = '{201, 201, 150, 201, 201, 201};
  bit          oc_exp [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    int unsigned first;
    int unsigned cnt;

    #1 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Metal press: single pulse, 7 cycles after the raw edge.
    metal_raw = 1'b1;
    first = 0; cnt = 0;
    for (int unsigned i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (metal_detected) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check("metal_pulse_pos", first, 7);
    check("metal_pulse_cnt", cnt, 1);
    metal_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Two-cycle glitch must be rejected.
    metal_raw = 1'b1;
    repeat (2) @(negedge clk);
    metal_raw = 1'b0;
    cnt = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      if (metal_detected) cnt++;
    end
    check("metal_glitch_cnt", cnt, 0);

    // Temperature hysteresis.
    for (int unsigned i = 0; i < 5; i++) begin
      temp_valid = 1'b1;
      temp_code  = TW'(temps[i]);
      @(negedge clk);
      temp_valid = 1'b0;
      check("temp_hot_seq", high_temp, hot_exp[i]);
      check("temp_norm_seq", temp_normal, !hot_exp[i]);
    end

    // Overcurrent needs three consecutive over-limit samples.
    for (int unsigned i = 0; i < 6; i++) begin
      current_code = CW'(curs[i]);
      @(negedge clk);
      check("oc_seq", overcurrent, oc_exp[i]);
    end
    current_code = CW'(150);
    press_button();
    check("oc_held_to_press", overcurrent, 1);
    @(negedge clk);
    check("oc_cleared", overcurrent, 0);
    reset_btn_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Press during over-limit: counter restarts at 1, trips two samples later.
    current_code = CW'(201);
    repeat (3) @(negedge clk);
    check("oc_retrip", overcurrent, 1);
    press_button();
    @(negedge clk);
    check("oc_conc_clear", overcurrent, 0);
    @(negedge clk);
    check("oc_conc_plus1", overcurrent, 0);
    @(negedge clk);
    check("oc_conc_plus2", overcurrent, 1);
    current_code = '0;
    reset_btn_raw = 1'b0;
    repeat (10) @(negedge clk);

    // E-stop assert after 6 cycles; bouncing release needs 4 clean lows.
    estop_raw = 1'b1;
    first = 0;
    for (int unsigned i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (emergency && first == 0) first = i;
    end
    check("estop_on_pos", first, 6);
    repeat (4) @(negedge clk);
    estop_raw = 1'b0;
    first = 0;
    for (int unsigned i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (!emergency && first == 0) first = i;
      estop_raw = (i == 1 || i == 3);
    end
    check("estop_off_pos", first, 10);
    repeat (4) @(negedge clk);

`ifdef SENSOR_WDOG_EN
    press_button();
    temp_valid    = 1'b1;
    reset_btn_raw = 1'b0;
    @(negedge clk);
    temp_valid = 1'b0;
    check("wd_cleared_with_valid", error, 0);
    repeat (15) @(negedge clk);
    check("wd_before_trip", error, 0);
    @(negedge clk);
    check("wd_trip", error, 1);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    @(negedge clk);
    check("wd_sticky", error, 1);
    repeat (8) @(negedge clk);
    press_button();
    @(negedge clk);
    check("wd_press_clear", error, 0);
    reset_btn_raw = 1'b0;
    repeat (10) @(negedge clk);
`else
    check("error_tied_low", error, 0);
`endif

    // Reset three cycles into a metal press; a fresh full debounce follows.
    metal_raw = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    first = 0; cnt = 0;
    for (int unsigned i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (metal_detected) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check("midrst_pulse_pos", first, 7);
    check("midrst_pulse_cnt", cnt, 1);
    metal_raw = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Front-end that produces the sensor-side inputs of `manufacturing_fsm` from raw plant signals. It synchronises and debounces the contact inputs, and applies hysteresis to the temperature samples. It also qualifies overcurrent over consecutive samples and watches the temperature sensor for a stalled feed. Its outputs connect one-to-one to the FSM's `metal_detected`, `high_temp`, `temp_normal`, `overcurrent`, `error`, `emergency` and `reset_btn` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples required to accept a level change (≥2).
- `TEMP_W`, 8: temperature code width, unsigned.
- `TEMP_HIGH`, 80: code at or above which the block is hot.
- `TEMP_LOW`, 70: code at or below which the block is normal. `TEMP_LOW < TEMP_HIGH` is required.
- `CUR_W`, 8: current code width, unsigned.
- `CUR_LIMIT`, 200: over-limit when `current_code > CUR_LIMIT`.
- `OC_CYCLES`, 3: consecutive over-limit cycles that trip overcurrent (≥1).
- `WDOG_CYCLES`, 16: temperature-feed timeout in cycles (only with `SENSOR_WDOG_EN`).

Ports:
- `clk` in 1: system clock, all flops on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `metal_raw` in 1: raw metal sensor contact, asynchronous.
- `estop_raw` in 1: raw emergency-stop contact, asynchronous.
- `reset_btn_raw` in 1: raw operator reset button, asynchronous.
- `temp_code` in TEMP_W: temperature sample, qualified by `temp_valid`.
- `temp_valid` in 1: one-cycle strobe, synchronous to `clk`.
- `current_code` in CUR_W: current sample, valid every cycle, synchronous.
- `metal_detected` out 1: one-cycle pulse per accepted rising edge of metal.
- `high_temp` out 1: hysteresis hot flag.
- `temp_normal` out 1: hysteresis normal flag; always equals `~high_temp`.
- `overcurrent` out 1: sticky overcurrent trip.
- `error` out 1: sticky sensor-feed fault.
- `emergency` out 1: debounced e-stop level.
- `reset_btn` out 1: one-cycle pulse per accepted press.

## Operation
- Reset values: `metal_detected`=0, `high_temp`=0, `temp_normal`=1, `overcurrent`=0, `error`=0, `emergency`=0, `reset_btn`=0. All synchroniser, counter and stable registers are 0.
- Each raw contact (metal, estop, reset button) passes through a 2-flop synchroniser, then a debouncer.
- Debouncer FSM has two states, STABLE_LO and STABLE_HI, plus a count register.
  - When the synchronised value differs from the state, count increments.
  - When it equals the state, count clears.
  - When count reaches `DEBOUNCE_CYCLES-1` and the value still differs, the state toggles and count clears.
- `metal_detected` and `reset_btn` are registered edge pulses, high for one cycle on each STABLE_LO→STABLE_HI transition. Falling edges produce nothing.
- `emergency` is the debouncer state itself.
- Temperature updates only on a cycle where `temp_valid`=1:
  - `temp_code >= TEMP_HIGH` → `high_temp`=1.
  - `temp_code <= TEMP_LOW` → `high_temp`=0.
  - Codes strictly between the two thresholds hold the current value.
- Overcurrent:
  - A saturating counter increments while `current_code > CUR_LIMIT` and clears otherwise.
  - The cycle the counter reaches `OC_CYCLES`, `overcurrent` sets and stays set.
  - An internal `reset_btn` pulse clears both `overcurrent` and the counter. If that pulse coincides with an over-limit cycle, the counter loads 1 and `overcurrent` clears.

## Timing
- Raw contact edge to debounced state change: `DEBOUNCE_CYCLES+2` cycles (the synchroniser adds 2).
- Edge pulses (`metal_detected`, `reset_btn`) appear 1 cycle after that state change.
- A raw glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Temperature: the sample is taken on the `temp_valid` edge, and `high_temp`/`temp_normal` change on that same edge (visible the next cycle).
- Overcurrent: `overcurrent` is high in the cycle after the `OC_CYCLES`-th consecutive over-limit sample.
- Asserting `rst` mid-operation forces all outputs to reset values immediately, without waiting for a clock edge. Partial debounce counts are discarded.

## Configuration
- `SENSOR_WDOG_EN` defined:
  - A watchdog counter clears on every `temp_valid` and increments otherwise, saturating.
  - On reaching `WDOG_CYCLES`, `error` sets and stays set.
  - A `reset_btn` pulse clears `error` and the counter. If `temp_valid` arrives on the same cycle, the result is the same: cleared.
- `SENSOR_WDOG_EN` undefined: `error` is tied to 0 and no watchdog logic is built.

## Test plan
- Metal contact: `metal_raw` 0→1 held for 10 cycles → `metal_detected` high for exactly 1 cycle, 7 cycles after the edge (defaults). A 2-cycle raw pulse → no pulse.
- Temperature hysteresis: valid codes 60, 85, 75, 71, 70 → `high_temp` goes 0, 1, 1, 1, 0, with `temp_normal` always its complement.
- Overcurrent: `current_code`=201 for 2 cycles, then 150, then 201 for 3 cycles → trips only after the third consecutive sample. A press then clears it when current is 150. A press concurrent with current 201 clears `overcurrent` and loads the counter to 1.
- E-stop: `estop_raw`=1 → `emergency`=1 after 6 cycles. A release bouncing 1-0-1-0 at 1-cycle spacing → `emergency` stays 1 until 4 clean low samples.
- Watchdog (macro on): no `temp_valid` for 16 cycles → `error`=1. `temp_valid` afterwards does not clear it; a debounced reset press does.
- Reset mid-debounce: `rst` asserted 3 cycles into a metal press → all outputs at reset values, and no pulse is emitted after `rst` deasserts unless the input is held for a fresh `DEBOUNCE_CYCLES+2` cycles.
